// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the binary dot-product PE sequencer.
package pe_seq_pkg;

  localparam int ACC_W  = 11;
  localparam int WORD_W = 16;

  // XNOR(00FF, 0000) = FF00 -> popcount 8 -> zero contribution to the PE sum
  localparam logic [WORD_W-1:0] NEUTRAL_WEIGHT = 16'h00FF;
  localparam logic [WORD_W-1:0] NEUTRAL_ACT    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bus bundle between the PE sequencer and its surroundings (scheduler job
// port, weight/activation buffers, PE, result handshake).
// Optional out_sign signal present when PE_SEQ_BINARIZE_EN is defined.
interface pe_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 6
) ();
  import pe_seq_pkg::*;

  // job request
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] wt_base;
  logic [ADDR_W-1:0] act_base;
  logic [ACC_W-1:0]  bias;
  logic              busy;
  // buffer read port
  logic              mem_rd_en;
  logic [ADDR_W-1:0] wt_addr;
  logic [ADDR_W-1:0] act_addr;
  logic [WORD_W-1:0] wt_rdata;
  logic [WORD_W-1:0] act_rdata;
  // PE side
  logic              pe_load;
  logic [WORD_W-1:0] pe_weight;
  logic [WORD_W-1:0] pe_activation;
  logic [ACC_W-1:0]  pe_acc_in;
  logic [ACC_W-1:0]  pe_acc_out;
  // result handshake
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
`ifdef PE_SEQ_BINARIZE_EN
  logic              out_sign;
`endif

  // sequencer side
  modport master (
    input  start, len, wt_base, act_base, bias,
    input  wt_rdata, act_rdata, pe_acc_out, out_ready,
    output busy, mem_rd_en, wt_addr, act_addr,
    output pe_load, pe_weight, pe_activation, pe_acc_in,
`ifdef PE_SEQ_BINARIZE_EN
    output out_sign,
`endif
    output out_valid, result
  );

  // environment side (scheduler, buffers, PE)
  modport slave (
    output start, len, wt_base, act_base, bias,
    output wt_rdata, act_rdata, pe_acc_out, out_ready,
    input  busy, mem_rd_en, wt_addr, act_addr,
    input  pe_load, pe_weight, pe_activation, pe_acc_in,
`ifdef PE_SEQ_BINARIZE_EN
    input  out_sign,
`endif
    input  out_valid, result
  );

endinterface

// File: rtl/pe_seq_delay.sv
// Parameterised flag shift register: o_q is i_d delayed by DEPTH cycles.
// Cleared by reset so that in-flight flags are dropped on abort.
module pe_seq_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;
      if (gi == 0) begin : g_head
        // first stage samples the input
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_q <= '0;
          else        r_q <= i_d;
        end
      end else begin : g_tail
        // later stages shift from the previous one
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_q <= '0;
          else        r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one binary XNOR/popcount dot-product PE.
// Accepts a job, streams K buffer words into the PE (bias loaded with word 0),
// waits for the PE pipeline to drain and returns the accumulator on a
// valid/ready output.
// Optional feature macro: PE_SEQ_BINARIZE_EN (adds out_sign = ~result[10]).
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 6,
  parameter int MEM_LAT = 1,
  parameter int PE_LAT  = 2
) (
  input logic          clk,
  input logic          rst_n,
  pe_seq_ctrl_if.master bus
);

  state_t            r_state,    w_state_next;
  logic [LEN_W-1:0]  r_cnt,      w_cnt_next;
  logic [ADDR_W-1:0] r_wt_addr,  w_wt_addr_next;
  logic [ADDR_W-1:0] r_act_addr, w_act_addr_next;
  logic [ACC_W-1:0]  r_bias,     w_bias_next;
  logic              r_rd_en,    w_rd_en_next;
  logic              r_first,    w_first_next;
  logic              r_last,     w_last_next;
  logic [ACC_W-1:0]  r_result,   w_result_next;
  logic              r_out_valid, w_out_valid_next;
`ifdef PE_SEQ_BINARIZE_EN
  logic              r_sign,     w_sign_next;
`endif

  // Read-issue flags realigned to the cycle the buffer data appears.
  logic [2:0] w_align;
  logic       w_valid;
  logic       w_first;
  logic       w_last;
  logic       w_drain_done;

  pe_seq_delay #(.WIDTH(3), .DEPTH(MEM_LAT)) u_mem_align (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({r_rd_en, r_first, r_last}),
    .o_q   (w_align)
  );

  assign w_valid = w_align[2];
  assign w_first = w_align[1];
  assign w_last  = w_align[0];

  // Last word enters the PE, then PE_LAT stages plus the accumulator register
  // before the final sum is visible on pe_acc_out.
  pe_seq_delay #(.WIDTH(1), .DEPTH(PE_LAT + 1)) u_drain (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_last),
    .o_q   (w_drain_done)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wt_addr   <= '0;
      r_act_addr  <= '0;
      r_bias      <= '0;
      r_rd_en     <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
`ifdef PE_SEQ_BINARIZE_EN
      r_sign      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_wt_addr   <= w_wt_addr_next;
      r_act_addr  <= w_act_addr_next;
      r_bias      <= w_bias_next;
      r_rd_en     <= w_rd_en_next;
      r_first     <= w_first_next;
      r_last      <= w_last_next;
      r_result    <= w_result_next;
      r_out_valid <= w_out_valid_next;
`ifdef PE_SEQ_BINARIZE_EN
      r_sign      <= w_sign_next;
`endif
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_wt_addr_next   = r_wt_addr;
    w_act_addr_next  = r_act_addr;
    w_bias_next      = r_bias;
    w_rd_en_next     = r_rd_en;
    w_first_next     = r_first;
    w_last_next      = r_last;
    w_result_next    = r_result;
    w_out_valid_next = r_out_valid;
`ifdef PE_SEQ_BINARIZE_EN
    w_sign_next      = r_sign;
`endif

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_bias_next = bus.bias;
          if (bus.len == '0) begin
            // empty job: the bias itself is the result
            w_result_next    = bus.bias;
            w_out_valid_next = 1'b1;
`ifdef PE_SEQ_BINARIZE_EN
            w_sign_next      = ~bus.bias[ACC_W-1];
`endif
            w_state_next     = OUT;
          end else begin
            w_rd_en_next    = 1'b1;
            w_first_next    = 1'b1;
            w_last_next     = (bus.len == LEN_W'(1));
            w_cnt_next      = bus.len - LEN_W'(1);
            w_wt_addr_next  = bus.wt_base;
            w_act_addr_next = bus.act_base;
            w_state_next    = ISSUE;
          end
        end
      end

      ISSUE: begin
        // r_cnt = reads still to issue after the current one
        w_first_next = 1'b0;
        if (r_cnt == '0) begin
          w_rd_en_next = 1'b0;
          w_last_next  = 1'b0;
          w_state_next = DRAIN;
        end else begin
          w_cnt_next      = r_cnt - LEN_W'(1);
          w_wt_addr_next  = r_wt_addr + ADDR_W'(1);
          w_act_addr_next = r_act_addr + ADDR_W'(1);
          w_last_next     = (r_cnt == LEN_W'(1));
        end
      end

      DRAIN: begin
        if (w_drain_done) begin
          w_result_next    = bus.pe_acc_out;
          w_out_valid_next = 1'b1;
`ifdef PE_SEQ_BINARIZE_EN
          w_sign_next      = ~bus.pe_acc_out[ACC_W-1];
`endif
          w_state_next     = OUT;
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.mem_rd_en     = r_rd_en;
  assign bus.wt_addr       = r_wt_addr;
  assign bus.act_addr      = r_act_addr;
  assign bus.pe_load       = w_first;
  // Any cycle without a real word must feed the neutral pair, since the PE
  // accumulates unconditionally.
  assign bus.pe_weight     = w_valid ? bus.wt_rdata  : NEUTRAL_WEIGHT;
  assign bus.pe_activation = w_valid ? bus.act_rdata : NEUTRAL_ACT;
  assign bus.pe_acc_in     = r_bias;
  assign bus.out_valid     = r_out_valid;
  assign bus.result        = r_result;
`ifdef PE_SEQ_BINARIZE_EN
  assign bus.out_sign      = r_sign;
`else
  // no binarized output in this build
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed testbench for pe_seq_ctrl with buffer and PE behavioural models.
module tb_pe_seq_ctrl;
  import pe_seq_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 6;
  localparam int MEM_LAT = 1;
  localparam int PE_LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pe_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  pe_seq_ctrl #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_LAT(MEM_LAT), .PE_LAT(PE_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous buffers, one cycle read latency
  logic [15:0] wmem [256];
  logic [15:0] amem [256];
  logic [15:0] wt_q  = 16'h0;
  logic [15:0] act_q = 16'h0;
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      wt_q  <= wmem[bus.wt_addr];
      act_q <= amem[bus.act_addr];
    end
  end
  assign bus.wt_rdata  = wt_q;
  assign bus.act_rdata = act_q;

  // PE model: XNOR/popcount contribution, two pipeline stages, accumulator
  function automatic logic [10:0] contrib(input logic [15:0] w, input logic [15:0] a);
    int p;
    p = $countones(~(w ^ a));
    return 11'(2 * p - 16);
  endfunction

  logic [10:0] c1 = 11'h0;
  logic [10:0] c2 = 11'h0;
  logic        l1 = 1'b0;
  logic        l2 = 1'b0;
  logic [10:0] acc = 11'h0;
  always @(posedge clk) begin
    c1  <= contrib(bus.pe_weight, bus.pe_activation);
    l1  <= bus.pe_load;
    c2  <= c1;
    l2  <= l1;
    acc <= l2 ? (bus.pe_acc_in + c2) : (acc + c2);
  end
  assign bus.pe_acc_out = acc;

  // Launch one job and watch until out_valid (bounded). Cycle numbers are
  // relative to the start cycle s.
  task automatic run_job(input int len, input int wb, input int ab, input int bias,
                         output logic [10:0] res, output int vcyc, output int load_n,
                         output int load_cyc, output int rd_n, output int data_n);
    res = 'x; vcyc = -1; load_n = 0; load_cyc = -1; rd_n = 0; data_n = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = LEN_W'(len);
    bus.wt_base  = ADDR_W'(wb);
    bus.act_base = ADDR_W'(ab);
    bus.bias     = 11'(bias);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.pe_load) begin load_n++; load_cyc = i; end
      if (bus.mem_rd_en) rd_n++;
      if (bus.pe_weight !== NEUTRAL_WEIGHT || bus.pe_activation !== NEUTRAL_ACT) data_n++;
      if (bus.out_valid === 1'b1) begin
        vcyc = i;
        res  = bus.result;
        break;
      end
    end
    $display("job len=%0d bias=%0d result=%0d valid_at=s+%0d load_at=s+%0d loads=%0d reads=%0d words=%0d",
             len, bias, $signed(res), vcyc, load_cyc, load_n, rd_n, data_n);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake got valid=%b busy=%b expected valid=0 busy=0", tag, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.mem_rd_en, bus.pe_load, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy/rd/load/valid=%b expected 0000",
               {bus.busy, bus.mem_rd_en, bus.pe_load, bus.out_valid});
    end
    checks++;
    if (bus.result !== 11'd0 || bus.wt_addr !== 8'd0 || bus.act_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got result=%h wt=%h act=%h expected 0 0 0", bus.result, bus.wt_addr, bus.act_addr);
    end
    checks++;
    if (bus.pe_weight !== 16'h00FF || bus.pe_activation !== 16'h0000) begin
      errors++;
      $display("FAIL reset_neutral got w=%h a=%h expected 00ff 0000", bus.pe_weight, bus.pe_activation);
    end
`ifdef PE_SEQ_BINARIZE_EN
    checks++;
    if (bus.out_sign !== 1'b0) begin
      errors++;
      $display("FAIL reset_sign got %b expected 0", bus.out_sign);
    end
`endif
    rst_n = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_match();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    for (int k = 0; k < 4; k++) begin
      wmem[10 + k] = 16'h1111 * 16'(k + 1);
      amem[20 + k] = 16'h1111 * 16'(k + 1);
    end
    run_job(4, 10, 20, 0, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'd64) begin errors++; $display("FAIL match_result got %0d expected 64", $signed(res)); end
    checks++;
    if (vc !== 9) begin errors++; $display("FAIL match_valid_cycle got s+%0d expected s+9", vc); end
    checks++;
    if (ln !== 1 || lc !== 2) begin errors++; $display("FAIL match_load got count=%0d at s+%0d expected 1 at s+2", ln, lc); end
    checks++;
    if (rn !== 4 || dn !== 4) begin errors++; $display("FAIL match_counts got reads=%0d words=%0d expected 4 4", rn, dn); end
    handshake("match");
  endtask

  task automatic test_opposite();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    // weight addresses 254, 255, 0 exercise wrap-around
    for (int k = 0; k < 3; k++) begin
      wmem[(254 + k) % 256] = 16'h3C5A + 16'(k * 16'h0101);
      amem[100 + k] = ~(16'h3C5A + 16'(k * 16'h0101));
    end
    run_job(3, 254, 100, -5, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'h7CB) begin errors++; $display("FAIL opposite_result got %h expected 7cb", res); end
    checks++;
    if (vc !== 8) begin errors++; $display("FAIL opposite_valid_cycle got s+%0d expected s+8", vc); end
    handshake("opposite");
  endtask

  task automatic test_zero_len();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    run_job(0, 5, 6, 100, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'd100 || vc !== 1) begin
      errors++; $display("FAIL zero_result got %0d at s+%0d expected 100 at s+1", $signed(res), vc);
    end
    checks++;
    if (rn !== 0 || ln !== 0 || dn !== 0) begin
      errors++; $display("FAIL zero_activity got reads=%0d loads=%0d words=%0d expected 0 0 0", rn, ln, dn);
    end
    handshake("zero");
  endtask

  task automatic test_stall();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    wmem[40] = 16'hBEEF; amem[50] = 16'hBEEF;
    wmem[41] = 16'h1357; amem[51] = 16'h1357;
    run_job(2, 40, 50, 1, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'd33 || vc !== 7) begin
      errors++; $display("FAIL stall_result got %0d at s+%0d expected 33 at s+7", $signed(res), vc);
    end
    for (int j = 1; j <= 5; j++) begin
      if (j == 2) begin bus.start = 1'b1; bus.len = 6'd5; end
      if (j == 3) bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.busy, bus.mem_rd_en} !== 3'b110 || bus.result !== 11'd33) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid/busy/rd=%b result=%0d expected 110 33",
                 j, {bus.out_valid, bus.busy, bus.mem_rd_en}, $signed(bus.result));
      end
    end
    handshake("stall");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
        errors++; $display("FAIL stall_no_queue got busy=%b rd=%b expected 0 0", bus.busy, bus.mem_rd_en);
      end
    end
    $display("stall test done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 6'd8; bus.wt_base = 8'd0; bus.act_base = 8'd0; bus.bias = 11'd9;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_flags got busy=%b rd=%b valid=%b expected 0 0 0", bus.busy, bus.mem_rd_en, bus.out_valid);
    end
    checks++;
    if (bus.pe_weight !== 16'h00FF || bus.pe_activation !== 16'h0000 || bus.pe_load !== 1'b0) begin
      errors++; $display("FAIL abort_neutral got w=%h a=%h load=%b expected 00ff 0000 0",
                         bus.pe_weight, bus.pe_activation, bus.pe_load);
    end
    $display("mid-job reset applied at cycle %0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;
    wmem[60] = 16'hA5A5; amem[70] = 16'hA5A5;
    wmem[61] = 16'h0F0E; amem[71] = 16'h0F0E;
    run_job(2, 60, 70, 3, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'd35 || vc !== 7 || lc !== 2) begin
      errors++; $display("FAIL after_abort got %0d valid s+%0d load s+%0d expected 35 s+7 s+2", $signed(res), vc, lc);
    end
    handshake("after_abort");
  endtask

  task automatic test_sign();
    logic [10:0] res; int vc, ln, lc, rn, dn;
    wmem[80] = 16'hFFFF; amem[90] = 16'h00FF;
    run_job(1, 80, 90, -1, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'h7FF || vc !== 6) begin
      errors++; $display("FAIL sign_neg_result got %h at s+%0d expected 7ff at s+6", res, vc);
    end
`ifdef PE_SEQ_BINARIZE_EN
    checks++;
    if (bus.out_sign !== 1'b0) begin errors++; $display("FAIL sign_neg_bit got %b expected 0", bus.out_sign); end
`endif
    handshake("sign_neg");
    run_job(1, 80, 90, 7, res, vc, ln, lc, rn, dn);
    checks++;
    if (res !== 11'd7) begin errors++; $display("FAIL sign_pos_result got %0d expected 7", $signed(res)); end
`ifdef PE_SEQ_BINARIZE_EN
    checks++;
    if (bus.out_sign !== 1'b1) begin errors++; $display("FAIL sign_pos_bit got %b expected 1", bus.out_sign); end
`endif
    handshake("sign_pos");
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.wt_base = '0; bus.act_base = '0;
    bus.bias = '0; bus.out_ready = 1'b0;
    for (int a = 0; a < 256; a++) begin
      wmem[a] = 16'($urandom);
      amem[a] = 16'($urandom);
    end
    test_reset();
    test_match();
    test_opposite();
    test_zero_len();
    test_stall();
    test_reset_mid();
    test_sign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Sequencer for one binary dot-product processing element: 11-bit signed accumulator fed by a 16-bit XNOR/popcount datapath with 2 pipeline stages.
- Accepts a job (length, two base addresses, bias), reads weight/activation words from synchronous buffers and streams them into the PE.
- Pulses the PE load with the bias, waits for the pipeline to drain, then returns the final accumulation on a valid/ready output.
- Sits between the layer-level scheduler and the PE/buffer pair.

Parameters:
- ADDR_W, 8: buffer address width.
- LEN_W, 6: job length field width, in 16-bit words.
- MEM_LAT, 1: buffer read latency in cycles (address to data), ≥1.
- PE_LAT, 2: PE pipeline stages between input and accumulator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  job request; accepted only in IDLE.
- len  in  LEN_W  number of words K; 0 is legal.
- wt_base  in  ADDR_W  first weight address.
- act_base  in  ADDR_W  first activation address.
- bias  in  11  signed initial accumulator value.
- busy  out  1  high whenever state != IDLE.
- mem_rd_en  out  1  buffer read strobe.
- wt_addr  out  ADDR_W  weight read address.
- act_addr  out  ADDR_W  activation read address.
- wt_rdata  in  16  weight data, MEM_LAT after address.
- act_rdata  in  16  activation data, MEM_LAT after address.
- pe_load  out  1  PE accumulator load.
- pe_weight  out  16  PE weight input.
- pe_activation  out  16  PE activation input.
- pe_acc_in  out  11  PE load value (= latched bias).
- pe_acc_out  in  11  PE accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- result  out  11  signed dot-product result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset forces IDLE, busy=0, mem_rd_en=0, pe_load=0, out_valid=0, result=0, addresses=0, pe_weight/pe_activation=NEUTRAL.
- NEUTRAL pair: weight 16'h00FF, activation 16'h0000. XNOR popcount is 8, so the PE contribution is 0.
  - pe_weight/pe_activation equal NEUTRAL in every cycle where no valid data word is presented.
  - The PE accumulates every cycle, so any non-neutral idle input corrupts the sum.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: start=1 latches len, bases and bias.
  - len=0: go to OUT with result=bias; out_valid at s+1.
  - Otherwise go to ISSUE.
- ISSUE: K cycles with mem_rd_en=1.
  - wt_addr=wt_base+k, act_addr=act_base+k, k=0..K-1.
  - Addresses wrap modulo 2^ADDR_W.
- Data alignment: a valid shift register of depth MEM_LAT tracks each issued read.
  - Word k is presented to the PE at cycle p+k, where p = s+1+MEM_LAT.
  - pe_load=1 only in cycle p, coincident with word 0.
- DRAIN: entered after the last issue. Waits until cycle p+K+PE_LAT, then captures pe_acc_out into result and goes to OUT.
- OUT: out_valid=1 from cycle p+K+PE_LAT+1 (= s+9 for K=4 with defaults).
  - result and out_valid are stable until out_ready=1, then return to IDLE.
  - out_ready in the same cycle out_valid rises completes the transfer in one cycle.
- start while busy is ignored; no queuing.
- Arithmetic: no saturation. The accumulator wraps modulo 2^11 in the PE; the caller bounds |bias|+16·K ≤ 1023.
- Reset mid-operation: abort immediately and drop in-flight reads.
  - The PE accumulator is not reset; the next job's pe_load overwrites it.
  - Neutral inputs keep it harmless meanwhile.

Optional Feature:
- Macro: PE_SEQ_BINARIZE_EN.
- Defined: adds output out_sign (1 bit) = ~result[10], registered with result and valid with out_valid. It is the binarized activation for the next layer. Reset value is 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package pe_seq_pkg holds:
  - NEUTRAL_WEIGHT and NEUTRAL_ACT constants;
  - ACC_W=11, WORD_W=16;
  - state enum typedef {IDLE, ISSUE, DRAIN, OUT}.
- One sub-module: pe_seq_delay, a parameterised valid/flag shift register reused for the MEM_LAT data-valid alignment and the PE_LAT drain count.

Test Plan:
- len=4, bias=0, wt_rdata==act_rdata for all words (+16 each) → result=64, out_valid at s+9, pe_load high exactly one cycle at s+2.
- len=3, bias=-5, wt_rdata=~act_rdata (-16 each) → result=-53 (11'h7CB).
- len=0, bias=100 → no mem_rd_en, no pe_load, result=100 with out_valid at s+1.
- len=2, out_ready held low 5 cycles, start pulsed during busy → result and out_valid stable, start ignored, busy=1 until handshake.
- rst_n low at s+4 of a len=8 job, then len=2, bias=3, matching words → busy=0 asynchronously, PE inputs NEUTRAL, second job result=35.
- len=1, bias=-1, weight 16'hFFFF, activation 16'h00FF (contribution 0) → result=-1; with PE_SEQ_BINARIZE_EN, out_sign=0; repeat with bias=7 → out_sign=1.
